// File: rtl/fir_result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_result_fifo: FWFT AXI-Stream result FIFO behind the FIR engine that  |
// | admits one frame at a time. Optional frame-length checker is built when  |
// | FIR_RESULT_TLAST_CHECK_EN is defined.                                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_result_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 8
) (
  input  logic                       axis_clk,
  input  logic                       axis_rst_n,
  input  logic                       s_tvalid,
  input  logic [pDATA_WIDTH-1:0]     s_tdata,
  input  logic                       s_tlast,
  output logic                       s_tready,
  output logic                       m_tvalid,
  output logic [pDATA_WIDTH-1:0]     m_tdata,
  output logic                       m_tlast,
  input  logic                       m_tready,
  input  logic [31:0]                data_length,
  input  logic                       err_clr,
  output logic [$clog2(pDEPTH):0]    level,
  output logic                       frame_done,
  output logic                       len_err
);

  localparam int                  c_ADDR_W = $clog2(pDEPTH);
  localparam logic [c_ADDR_W:0]   c_FULL   = (c_ADDR_W + 1)'(pDEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  logic [pDATA_WIDTH:0]   r_mem [pDEPTH];
  logic [c_ADDR_W-1:0]    r_wr_ptr;
  logic [c_ADDR_W-1:0]    r_rd_ptr;
  logic [c_ADDR_W:0]      r_level;
  state_t                 r_state;
  logic                   r_s_tready;
  logic                   r_frame_done;
  logic [31:0]            r_beat_cnt;

  logic                   w_push;
  logic                   w_pop;
  logic [pDATA_WIDTH:0]   w_head;
  logic [c_ADDR_W:0]      w_level_nxt;
  state_t                 w_state_nxt;
  logic                   w_ready_nxt;

  assign w_push = s_tvalid && r_s_tready;
  assign w_pop  = (r_level != '0) && m_tready;
  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + 1'b1;
    else if (!w_push && w_pop)
      w_level_nxt = r_level - 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_push) w_state_nxt = s_tlast ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (w_push && s_tlast) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_pop && w_head[pDATA_WIDTH]) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Ready stays low for the whole DRAIN stay, including its entry and exit
  // cycles, so a beat of the next frame can never slip in behind tlast.
  assign w_ready_nxt = (w_level_nxt < c_FULL) && (r_state != ST_DRAIN)
                       && (w_state_nxt != ST_DRAIN);

  always_ff @(posedge axis_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {s_tlast, s_tdata};
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_state      <= ST_IDLE;
      r_s_tready   <= 1'b0;
      r_frame_done <= 1'b0;
      r_beat_cnt   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level      <= w_level_nxt;
      r_state      <= w_state_nxt;
      r_s_tready   <= w_ready_nxt;
      r_frame_done <= w_pop && w_head[pDATA_WIDTH];
      if (w_push)
        r_beat_cnt <= (w_state_nxt == ST_DRAIN) ? '0 : r_beat_cnt + 32'd1;
    end
  end

  // Head is gated so the data outputs read zero whenever the FIFO is empty.
  assign m_tvalid   = (r_level != '0);
  assign m_tdata    = m_tvalid ? w_head[pDATA_WIDTH-1:0] : '0;
  assign m_tlast    = m_tvalid && w_head[pDATA_WIDTH];
  assign s_tready   = r_s_tready;
  assign level      = r_level;
  assign frame_done = r_frame_done;

`ifdef FIR_RESULT_TLAST_CHECK_EN
  logic w_len_bad;
  logic r_len_err;

  // r_beat_cnt holds beats already accepted, excluding the current one.
  assign w_len_bad = w_push && (s_tlast ? ((r_beat_cnt + 32'd1) != data_length)
                                        : (r_beat_cnt == data_length));

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n)
      r_len_err <= 1'b0;
    else if (w_len_bad)
      r_len_err <= 1'b1;
    else if (err_clr)
      r_len_err <= 1'b0;
  end

  assign len_err = r_len_err;
`else
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, data_length, err_clr, r_beat_cnt};
  assign len_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_result_fifo: directed self-checking bench for fir_result_fifo.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fir_result_fifo;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic [31:0] data_length;
  logic        err_clr;
  logic [3:0]  level;
  logic        frame_done;
  logic        len_err;

  int          checks = 0;
  int          errors = 0;
  int          sent;
  int          fd_cnt;
  logic [32:0] exp_q[$];
  bit          stalled_prev;
  logic [32:0] held;
  bit          exp_len_err;

  fir_result_fifo #(.pDATA_WIDTH(32), .pDEPTH(8)) dut (
    .axis_clk    (axis_clk),
    .axis_rst_n  (axis_rst_n),
    .s_tvalid    (s_tvalid),
    .s_tdata     (s_tdata),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tvalid    (m_tvalid),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .data_length (data_length),
    .err_clr     (err_clr),
    .level       (level),
    .frame_done  (frame_done),
    .len_err     (len_err)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already set; records the handshakes of the
  // coming rising edge and returns at the following negedge.
  task automatic step();
    logic [32:0] exp_v;
    #1;
    if (s_tvalid && s_tready) begin
      exp_q.push_back({s_tlast, s_tdata});
      sent++;
    end
    if (m_tvalid && m_tready) begin
      exp_v = 33'h1_DEAD_BEEF;
      if (exp_q.size() != 0) exp_v = exp_q.pop_front();
      chk("m_beat", {m_tlast, m_tdata}, exp_v);
    end
    if (stalled_prev && m_tvalid) chk("stall_hold", {m_tlast, m_tdata}, held);
    stalled_prev = m_tvalid && !m_tready;
    held         = {m_tlast, m_tdata};
    if (frame_done) fd_cnt++;
    @(posedge axis_clk);
    @(negedge axis_clk);
  endtask

  // rmode: 0 = always ready, 1 = random 50%, 2 = never ready.
  task automatic run(input string tag, input int n, input int last_idx,
                     input int rmode, input int max_cyc, input bit expect_done);
    int cyc = 0;
    while ((sent < n || exp_q.size() != 0) && cyc < max_cyc) begin
      s_tvalid = (sent < n);
      s_tdata  = 32'(sent) ^ 32'hA5A5_0000;
      s_tlast  = (sent == last_idx);
      m_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (expect_done) begin
      chk({tag, "_done"}, (sent >= n && exp_q.size() == 0), 1);
      m_tready = 1'b1;
      step();
      step();
    end
  endtask

  initial begin
    axis_rst_n  = 1'b0;
    s_tvalid    = 1'b0;
    s_tdata     = '0;
    s_tlast     = 1'b0;
    m_tready    = 1'b1;
    data_length = 32'd600;
    err_clr     = 1'b0;
    sent = 0; fd_cnt = 0; stalled_prev = 0; held = '0;
`ifdef FIR_RESULT_TLAST_CHECK_EN
    exp_len_err = 1'b1;
`else
    exp_len_err = 1'b0;
`endif

    // Reset state
    @(negedge axis_clk);
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_level", level, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_len_err", len_err, 0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    #1;
    chk("rel_s_tready_before_edge", s_tready, 0);
    @(negedge axis_clk);
    chk("rel_s_tready_after_edge", s_tready, 1);

    // Full 600-beat frame, always ready
    sent = 0; fd_cnt = 0;
    run("f600", 600, 599, 0, 2000, 1);
    chk("f600_frame_done_cnt", fd_cnt, 1);
    chk("f600_len_err", len_err, 0);
    chk("f600_level", level, 0);

    // Backpressure: 10 offered, 8 accepted while stalled
    data_length = 32'd10;
    sent = 0; fd_cnt = 0;
    run("stall10", 10, 9, 2, 12, 0);
    chk("stall10_accepted", sent, 8);
    chk("stall10_s_tready", s_tready, 0);
    chk("stall10_level", level, 8);
    chk("stall10_m_tvalid", m_tvalid, 1);
    run("stall10", 10, 9, 0, 200, 1);
    chk("stall10_frame_done_cnt", fd_cnt, 1);
    chk("stall10_len_err", len_err, 0);

    // Random downstream ready, 600-beat frame
    data_length = 32'd600;
    sent = 0; fd_cnt = 0;
    run("rand600", 600, 599, 1, 5000, 1);
    chk("rand600_frame_done_cnt", fd_cnt, 1);
    chk("rand600_len_err", len_err, 0);

    // Short frame: tlast on beat 599 with data_length 600
    sent = 0; fd_cnt = 0;
    run("short599", 599, 598, 0, 2000, 1);
    chk("short599_frame_done_cnt", fd_cnt, 1);
    chk("short599_len_err", len_err, exp_len_err);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr_len_err", len_err, 0);

    // tlast accepted while FIFO already holds 3 beats
    data_length = 32'd4;
    sent = 0; fd_cnt = 0;
    run("tl3", 4, 3, 2, 6, 0);
    chk("tl3_accepted", sent, 4);
    chk("tl3_level", level, 4);
    chk("tl3_s_tready", s_tready, 0);
    for (int k = 0; k < 3; k++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'hBAD0_0000 + 32'(k);
      m_tready = 1'b1;
      step();
      chk("tl3_pop_s_tready", s_tready, 0);
      chk("tl3_pop_frame_done", frame_done, 0);
    end
    s_tvalid = 1'b0;
    step();
    chk("tl3_last_pop_frame_done", frame_done, 1);
    chk("tl3_last_pop_s_tready", s_tready, 0);
    chk("tl3_last_pop_level", level, 0);
    step();
    chk("tl3_after_s_tready", s_tready, 1);
    chk("tl3_after_frame_done", frame_done, 0);
    chk("tl3_len_err", len_err, 0);

    // Asynchronous reset with 5 beats held
    sent = 0; fd_cnt = 0;
    run("rst5", 5, 99, 2, 5, 0);
    chk("rst5_level", level, 5);
    axis_rst_n = 1'b0;
    #1;
    chk("rst5_level_now", level, 0);
    chk("rst5_m_tvalid_now", m_tvalid, 0);
    chk("rst5_m_tdata_now", m_tdata, 0);
    chk("rst5_m_tlast_now", m_tlast, 0);
    chk("rst5_s_tready_now", s_tready, 0);
    exp_q.delete();
    stalled_prev = 0;
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    m_tready   = 1'b1;
    @(negedge axis_clk);
    chk("rst5_rel_s_tready", s_tready, 1);
    chk("rst5_rel_level", level, 0);
    chk("rst5_rel_frame_done", frame_done, 0);

    // Clean frame after reset: pointers and FSM restarted
    data_length = 32'd3;
    sent = 0; fd_cnt = 0;
    run("post3", 3, 2, 0, 100, 1);
    chk("post3_frame_done_cnt", fd_cnt, 1);
    chk("post3_len_err", len_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
